split_rr_arbiter: RTL and testbench
===================================

Name: split_rr_arbiter

Overview:
- Serial-bus arbiter for N initiator ports plus one split-target port, with split-transaction tracking.
- Grants bus ownership round-robin among initiators.
- When a target splits a transaction, records the owning initiator, blocks its re-requests and gives the split target top priority to return read data.
- Provides a hold-time watchdog and a one-hot-equivalent mux select for the bus datapath.

Parameters:
- NUM_INIT, 2, number of initiator requesters (2..4).
- TIMEOUT, 256, maximum cycles any grant may be held; 0 disables the watchdog.
- SEL_W, $clog2(NUM_INIT+1), width of the sel output (derived, not overridden).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  active-low reset.
- req_i  input  NUM_INIT  per-initiator bus request (level).
- req_split  input  1  split-target request to return data (level).
- split_ack  input  1  one-cycle pulse from the target port: current initiator transaction was split.
- grant_i  output  NUM_INIT  per-initiator grant, at most one bit high.
- grant_split  output  1  split-target grant.
- sel  output  SEL_W  bus mux select: 0..NUM_INIT-1 = initiator index, NUM_INIT = split target.
- split_pending  output  1  a split transaction is outstanding.
- split_owner  output  SEL_W  index of the initiator that owns the outstanding split.
- timeout_err  output  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset is asynchronous, active-low; clock is clk. All outputs are registered.
- Reset values:
  - grant_i=0, grant_split=0, sel=0.
  - split_pending=0, split_owner=0, timeout_err=0.
  - Round-robin pointer=NUM_INIT-1, so initiator 0 wins first; hold counter=0; state=IDLE.
- FSM states: IDLE, GRANT_INIT, GRANT_SPLIT, GAP.
- IDLE:
  - If req_split && split_pending: go to GRANT_SPLIT; grant_split=1, sel=NUM_INIT on the next edge.
  - Else pick the first asserted eligible req_i scanning from pointer+1 with wrap.
  - An initiator is eligible unless split_pending && index==split_owner.
  - On a pick: GRANT_INIT, grant_i[k]=1, sel=k, pointer=k.
  - Request-to-grant latency is 1 cycle from IDLE.
- GRANT_INIT (owner k):
  - Grant held while req_i[k]=1.
  - On req_i[k]=0: drop the grant and go to GAP.
  - split_ack in this state while split_pending=0: on the next edge split_pending=1, split_owner=k. The grant is still held until req_i[k] drops.
  - split_ack while split_pending=1: ignored, since only one split is outstanding.
- GRANT_SPLIT:
  - Held while req_split=1.
  - On req_split=0: grant_split=0, split_pending=0, go to GAP.
- GAP:
  - Exactly one cycle with all grants low; sel keeps its last value.
  - Then go to IDLE.
  - A new grant therefore appears no earlier than 2 cycles after the previous grant drops.
- Watchdog:
  - Counter clears on entry to GRANT_INIT or GRANT_SPLIT and increments each cycle a grant is held.
  - When TIMEOUT!=0 and the count reaches TIMEOUT-1 with the request still high: grants drop on the next edge, timeout_err pulses for 1 cycle, FSM goes to GAP.
  - Timeout in GRANT_SPLIT also clears split_pending.
  - Timeout in GRANT_INIT leaves split state unchanged.
- Boundary rules:
  - split_ack outside GRANT_INIT is ignored.
  - req_split with split_pending=0 is ignored; it never wins.
  - Simultaneous req_split and initiator requests in IDLE: split wins.
  - Blocked owner requesting alone: no grant; FSM stays IDLE.
  - Reset asserted mid-grant: all outputs return to reset values immediately (asynchronous); split state is lost.
  - The round-robin pointer is not updated by split grants.

Decomposition:
- Shared package bus_arb_pkg:
  - arb_state_e enum (IDLE, GRANT_INIT, GRANT_SPLIT, GAP).
  - SEL encoding constants: SEL_SPLIT derived from NUM_INIT.
  - Default TIMEOUT.
- Sub-module rr_pick: combinational rotating-priority picker.
  - Inputs: req vector, mask vector, pointer.
  - Outputs: found, index.
- The FSM, split tracking and watchdog live in split_rr_arbiter.

Test Plan:
- Single request: req_i=01 from IDLE -> grant_i=01, sel=0 one cycle later; drop req -> grant low next edge, one GAP cycle.
- Fairness: req_i=11 held continuously, each owner drops req after 3 granted cycles and reasserts -> grants alternate 0,1,0,1 with a 1-cycle all-low gap between them.
- Split flow:
  - Initiator 0 granted; split_ack pulse; req_i[0] drops and reasserts -> split_pending=1, split_owner=0, initiator 0 not granted.
  - req_split=1 -> grant_split=1, sel=2.
  - req_split drops -> split_pending=0; initiator 0 granted after GAP.
- Priority: req_split and req_i=10 rise together in IDLE while split_pending=1 -> grant_split wins; initiator 1 is granted after the split grant releases plus GAP.
- Watchdog: TIMEOUT=8, req_i[1] held high -> grant_i[1] high for exactly 8 cycles, timeout_err single pulse, then GAP.
- Reset mid-operation: assert rst_n=0 during GRANT_SPLIT -> grant_split, split_pending, sel, timeout_err all 0 without a clock edge; after release, req_i=10 -> grant_i=10 after 1 cycle.

Source files
------------

// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arb_pkg
// Description : Shared types and constants for the split-transaction arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT_INIT  = 2'd1,
        GRANT_SPLIT = 2'd2,
        GAP         = 2'd3
    } arb_state_e;

    localparam int c_DEFAULT_TIMEOUT = 256;

    // The split target sits just past the last initiator in the select space.
    function automatic int sel_split(input int num_init);
        return num_init;
    endfunction

    function automatic int sel_width(input int num_init);
        return $clog2(num_init + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/split_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : split_rr_arbiter_if
// Description : Request/grant bundle between the arbiter and the bus ports.
// Revision    : 1.0 - initial release
// ============================================================================
interface split_rr_arbiter_if
    import bus_arb_pkg::*;
#(
    parameter int NUM_INIT = 2
);
    localparam int SEL_W = sel_width(NUM_INIT);

    logic [NUM_INIT-1:0] req_i;
    logic                req_split;
    logic                split_ack;
    logic [NUM_INIT-1:0] grant_i;
    logic                grant_split;
    logic [SEL_W-1:0]    sel;
    logic                split_pending;
    logic [SEL_W-1:0]    split_owner;
    logic                timeout_err;

    modport master (
        input  req_i, req_split, split_ack,
        output grant_i, grant_split, sel, split_pending, split_owner, timeout_err
    );

    modport slave (
        output req_i, req_split, split_ack,
        input  grant_i, grant_split, sel, split_pending, split_owner, timeout_err
    );

endinterface
`default_nettype wire

// File: rtl/split_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating-priority picker, scanning from ptr+1.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int NUM_INIT = 2,
    parameter int SEL_W    = 2
) (
    input  wire logic [NUM_INIT-1:0] req,
    input  wire logic [NUM_INIT-1:0] mask,
    input  wire logic [SEL_W-1:0]    ptr,
    output logic                     found,
    output logic [SEL_W-1:0]         index
);

    int w_k;

    // Scan farthest-first so the nearest hit after ptr overwrites the rest.
    always_comb begin
        found = 1'b0;
        index = '0;
        w_k   = 0;
        for (int i = NUM_INIT; i >= 1; i--) begin
            w_k = (int'(ptr) + i) % NUM_INIT;
            if (req[w_k] && mask[w_k]) begin
                found = 1'b1;
                index = SEL_W'(w_k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/split_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : split_rr_arbiter
// Description : Round-robin bus arbiter with split-target priority and watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module split_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_INIT = 2,
    parameter int TIMEOUT  = c_DEFAULT_TIMEOUT
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    split_rr_arbiter_if.master bus
);

    localparam int SEL_W   = sel_width(NUM_INIT);
    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [SEL_W-1:0]   c_SEL_SPLIT = SEL_W'(sel_split(NUM_INIT));

    arb_state_e          r_state;
    logic [NUM_INIT-1:0] r_grant_i;
    logic                r_grant_split;
    logic [SEL_W-1:0]    r_sel;
    logic                r_split_pending;
    logic [SEL_W-1:0]    r_split_owner;
    logic                r_timeout_err;
    logic [SEL_W-1:0]    r_ptr;
    logic [c_CNT_W-1:0]  r_cnt;

    logic [NUM_INIT-1:0] w_mask;
    logic [NUM_INIT-1:0] w_pick_oh;
    logic                w_found;
    logic [SEL_W-1:0]    w_pick_idx;
    logic                w_owner_req;
    logic                w_expire;

    always_comb begin
        w_mask    = '0;
        w_pick_oh = '0;
        for (int i = 0; i < NUM_INIT; i++) begin
            w_mask[i]    = !(r_split_pending && (r_split_owner == SEL_W'(i)));
            w_pick_oh[i] = (w_pick_idx == SEL_W'(i));
        end
    end

    rr_pick #(
        .NUM_INIT (NUM_INIT),
        .SEL_W    (SEL_W)
    ) u_pick (
        .req   (bus.req_i),
        .mask  (w_mask),
        .ptr   (r_ptr),
        .found (w_found),
        .index (w_pick_idx)
    );

    // The one-hot grant doubles as the owner mask for the held request.
    assign w_owner_req = |(bus.req_i & r_grant_i);
    assign w_expire    = (TIMEOUT != 0) && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_grant_i       <= '0;
            r_grant_split   <= 1'b0;
            r_sel           <= '0;
            r_split_pending <= 1'b0;
            r_split_owner   <= '0;
            r_timeout_err   <= 1'b0;
            r_ptr           <= SEL_W'(NUM_INIT - 1);
            r_cnt           <= '0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_split && r_split_pending) begin
                        r_state       <= GRANT_SPLIT;
                        r_grant_split <= 1'b1;
                        r_sel         <= c_SEL_SPLIT;
                        r_cnt         <= '0;
                    end else if (w_found) begin
                        r_state   <= GRANT_INIT;
                        r_grant_i <= w_pick_oh;
                        r_sel     <= w_pick_idx;
                        r_ptr     <= w_pick_idx;
                        r_cnt     <= '0;
                    end
                end
                GRANT_INIT: begin
                    if (bus.split_ack && !r_split_pending) begin
                        r_split_pending <= 1'b1;
                        r_split_owner   <= r_sel;
                    end
                    if (!w_owner_req) begin
                        r_grant_i <= '0;
                        r_state   <= GAP;
                    end else if (w_expire) begin
                        r_grant_i     <= '0;
                        r_timeout_err <= 1'b1;
                        r_state       <= GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                GRANT_SPLIT: begin
                    if (!bus.req_split || w_expire) begin
                        r_grant_split   <= 1'b0;
                        r_split_pending <= 1'b0;
                        r_timeout_err   <= bus.req_split;
                        r_state         <= GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                GAP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant_i       = r_grant_i;
    assign bus.grant_split   = r_grant_split;
    assign bus.sel           = r_sel;
    assign bus.split_pending = r_split_pending;
    assign bus.split_owner   = r_split_owner;
    assign bus.timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_split_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_split_rr_arbiter
// Description : Directed self-checking bench for split_rr_arbiter (2 initiators).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_split_rr_arbiter;

    logic clk;
    logic rst_n;

    split_rr_arbiter_if #(.NUM_INIT(2)) bus_if ();

    split_rr_arbiter #(
        .NUM_INIT (2),
        .TIMEOUT  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [1:0] gi;
        logic       gs;
        logic [1:0] sel;
        logic       sp;
        logic [1:0] so;
        logic       te;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [1:0] gi, input logic gs,
                            input logic [1:0] sel, input logic sp, input logic [1:0] so,
                            input logic te);
        exp_t e;
        e.tag = tag; e.gi = gi; e.gs = gs; e.sel = sel; e.sp = sp; e.so = so; e.te = te;
        sb_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        e = sb_q.pop_front();
        n_checks++;
        assert (bus_if.grant_i === e.gi) else begin
            n_fail++; $error("FAIL %s grant_i observed=%b expected=%b", e.tag, bus_if.grant_i, e.gi);
        end
        n_checks++;
        assert (bus_if.grant_split === e.gs) else begin
            n_fail++; $error("FAIL %s grant_split observed=%b expected=%b", e.tag, bus_if.grant_split, e.gs);
        end
        n_checks++;
        assert (bus_if.sel === e.sel) else begin
            n_fail++; $error("FAIL %s sel observed=%0d expected=%0d", e.tag, bus_if.sel, e.sel);
        end
        n_checks++;
        assert (bus_if.split_pending === e.sp) else begin
            n_fail++; $error("FAIL %s split_pending observed=%b expected=%b", e.tag, bus_if.split_pending, e.sp);
        end
        n_checks++;
        assert (bus_if.split_owner === e.so) else begin
            n_fail++; $error("FAIL %s split_owner observed=%0d expected=%0d", e.tag, bus_if.split_owner, e.so);
        end
        n_checks++;
        assert (bus_if.timeout_err === e.te) else begin
            n_fail++; $error("FAIL %s timeout_err observed=%b expected=%b", e.tag, bus_if.timeout_err, e.te);
        end
    endtask

    task automatic expect_now(input string tag, input logic [1:0] gi, input logic gs,
                              input logic [1:0] sel, input logic sp, input logic [1:0] so,
                              input logic te);
        push_exp(tag, gi, gs, sel, sp, so, te);
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [1:0] oh;
        rst_n            = 1'b0;
        bus_if.req_i     = 2'b00;
        bus_if.req_split = 1'b0;
        bus_if.split_ack = 1'b0;
        step(2);
        expect_now("reset", 2'b00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;

        // split request without a pending split never wins
        bus_if.req_split = 1'b1;
        step(2);
        expect_now("split_no_pending", 2'b00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        bus_if.req_split = 1'b0;

        // single request
        bus_if.req_i = 2'b01;
        step(1); expect_now("single_grant", 2'b01, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        step(1); expect_now("single_hold",  2'b01, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        bus_if.req_i = 2'b00;
        step(1); expect_now("single_drop",  2'b00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        step(1); expect_now("single_gap",   2'b00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);

        // fairness: pointer sits at 0, so initiator 1 goes first
        bus_if.req_i = 2'b11;
        for (int r = 0; r < 4; r++) begin
            int w;
            w  = (r % 2 == 0) ? 1 : 0;
            oh = (w == 1) ? 2'b10 : 2'b01;
            step(1); expect_now($sformatf("fair_grant%0d", r), oh, 1'b0, 2'(w), 1'b0, 2'd0, 1'b0);
            step(2); expect_now($sformatf("fair_hold%0d", r),  oh, 1'b0, 2'(w), 1'b0, 2'd0, 1'b0);
            bus_if.req_i[w] = 1'b0;
            step(1); expect_now($sformatf("fair_drop%0d", r), 2'b00, 1'b0, 2'(w), 1'b0, 2'd0, 1'b0);
            bus_if.req_i[w] = 1'b1;
            step(1); expect_now($sformatf("fair_gap%0d", r),  2'b00, 1'b0, 2'(w), 1'b0, 2'd0, 1'b0);
        end
        bus_if.req_i = 2'b00;
        step(1);

        // split flow
        bus_if.req_i = 2'b01;
        step(1); expect_now("split_grant0", 2'b01, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        bus_if.split_ack = 1'b1;
        step(1); expect_now("split_ack",    2'b01, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
        bus_if.split_ack = 1'b0;
        bus_if.req_i = 2'b00;
        step(1); expect_now("split_drop",   2'b00, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
        bus_if.req_i = 2'b01;
        step(1); expect_now("split_gap",    2'b00, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
        step(2); expect_now("owner_blocked", 2'b00, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
        bus_if.req_split = 1'b1;
        step(1); expect_now("split_grant",  2'b00, 1'b1, 2'd2, 1'b1, 2'd0, 1'b0);
        step(1); expect_now("split_hold",   2'b00, 1'b1, 2'd2, 1'b1, 2'd0, 1'b0);
        bus_if.req_split = 1'b0;
        step(1); expect_now("split_release", 2'b00, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0);
        step(1); expect_now("split_rel_gap", 2'b00, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0);
        step(1); expect_now("owner_regrant", 2'b01, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        bus_if.req_i = 2'b00;
        step(2);

        // priority: split versus initiator 1 in the same IDLE cycle
        bus_if.req_i = 2'b01;
        step(1); expect_now("prio_setup_grant", 2'b01, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        bus_if.split_ack = 1'b1;
        step(1);
        bus_if.split_ack = 1'b0;
        bus_if.req_i = 2'b00;
        step(2); expect_now("prio_setup_idle", 2'b00, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
        bus_if.req_split = 1'b1;
        bus_if.req_i     = 2'b10;
        step(1); expect_now("prio_split_wins", 2'b00, 1'b1, 2'd2, 1'b1, 2'd0, 1'b0);
        bus_if.req_split = 1'b0;
        step(1); expect_now("prio_release",   2'b00, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0);
        bus_if.split_ack = 1'b1;
        step(1); expect_now("ack_ignored_gap", 2'b00, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0);
        step(1); expect_now("prio_init1",     2'b10, 1'b0, 2'd1, 1'b0, 2'd0, 1'b0);
        bus_if.split_ack = 1'b0;

        // watchdog: grant began one edge ago, expect 8 high cycles total
        for (int c = 0; c < 7; c++) begin
            step(1); expect_now($sformatf("wd_hold%0d", c), 2'b10, 1'b0, 2'd1, 1'b0, 2'd0, 1'b0);
        end
        step(1); expect_now("wd_expire", 2'b00, 1'b0, 2'd1, 1'b0, 2'd0, 1'b1);
        bus_if.req_i = 2'b00;
        step(1); expect_now("wd_gap",    2'b00, 1'b0, 2'd1, 1'b0, 2'd0, 1'b0);
        step(1);

        // reset during a split grant
        bus_if.req_i = 2'b01;
        step(1); expect_now("rst_setup_grant", 2'b01, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        bus_if.split_ack = 1'b1;
        step(1);
        bus_if.split_ack = 1'b0;
        bus_if.req_i = 2'b00;
        step(2);
        bus_if.req_split = 1'b1;
        step(1); expect_now("rst_split_grant", 2'b00, 1'b1, 2'd2, 1'b1, 2'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_now("rst_async", 2'b00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        bus_if.req_split = 1'b0;
        step(1);
        rst_n = 1'b1;
        bus_if.req_i = 2'b10;
        step(1); expect_now("rst_after_grant", 2'b10, 1'b0, 2'd1, 1'b0, 2'd0, 1'b0);
        bus_if.req_i = 2'b00;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
